// File: rtl/jesd_pkg.sv
// Shared definitions for the JESD reset sequencer: FSM state encoding and
// the constant functions used to size the shared cycle counter.
package jesd_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_WAIT_DONE = 3'd1,
      ST_RETRY     = 3'd2,
      ST_CORE_HOLD = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5
   } seq_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((longint'(1) << r) < longint'(value)) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/jesd_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the coreclk domain.
module jesd_sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_r;

   // capture stage followed by the resolved output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_r <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/jesd_reset_seq.sv
// Reset sequencer for the GT and JESD core: waits for stable PLL lock, releases
// the GT, waits for GT reset-done with bounded retries, then releases the core.
module jesd_reset_seq
   import jesd_pkg::*;
#(
   parameter int STABLE_CYCLES = 1024,
   parameter int DONE_TIMEOUT  = 65535,
   parameter int GT_RST_PULSE  = 16,
   parameter int CORE_HOLD     = 64,
   parameter int RETRY_MAX     = 3
) (
   input  logic       coreclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       gt_reset_done,
   output logic       gt_reset,
   output logic       core_reset,
   output logic       seq_done,
   output logic       seq_error,
   output logic [3:0] retry_count
);

   localparam int CW = max2(1, clog2(max2(max2(STABLE_CYCLES, DONE_TIMEOUT),
                                          max2(CORE_HOLD, GT_RST_PULSE))));
   localparam logic [CW-1:0] LOCK_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] DONE_LAST  = CW'(DONE_TIMEOUT - 1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(GT_RST_PULSE - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(CORE_HOLD - 1);
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [3:0]    RETRY_LIM  = 4'(RETRY_MAX);

   logic          pll_locked_s;
   logic          gt_reset_done_s;
   seq_state_e    state_r, state_nxt_s;
   logic [CW-1:0] cnt_r, cnt_nxt_s;
   logic [3:0]    retry_r, retry_nxt_s;
   logic          gt_reset_nxt_s, core_reset_nxt_s, seq_done_nxt_s, seq_error_nxt_s;

   jesd_sync_2ff u_sync_lock (.clk(coreclk), .rst(rst), .d(pll_locked),    .q(pll_locked_s));
   jesd_sync_2ff u_sync_done (.clk(coreclk), .rst(rst), .d(gt_reset_done), .q(gt_reset_done_s));

   // state, shared counter and retry tally
   always_ff @(posedge coreclk or posedge rst) begin
      if (rst) begin
         state_r <= ST_WAIT_LOCK;
         cnt_r   <= CNT_ZERO;
         retry_r <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         retry_r <= retry_nxt_s;
      end
   end

   // next-state logic; the counter is cleared on every state change
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      retry_nxt_s = retry_r;
      case (state_r)
         ST_WAIT_LOCK: begin
            if (!pll_locked_s) begin
               cnt_nxt_s = CNT_ZERO;
            end else if (cnt_r == LOCK_LAST) begin
               state_nxt_s = ST_WAIT_DONE;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_WAIT_DONE: begin
            // reset-done beats a coincident timeout
            if (gt_reset_done_s) begin
               state_nxt_s = ST_CORE_HOLD;
               cnt_nxt_s   = CNT_ZERO;
            end else if (!pll_locked_s) begin
               state_nxt_s = ST_WAIT_LOCK;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == DONE_LAST) begin
               cnt_nxt_s = CNT_ZERO;
               if (retry_r == RETRY_LIM) begin
                  state_nxt_s = ST_FAIL;
               end else begin
                  state_nxt_s = ST_RETRY;
                  retry_nxt_s = (retry_r == 4'd15) ? retry_r : retry_r + 4'd1;
               end
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_RETRY: begin
            if (cnt_r == PULSE_LAST) begin
               state_nxt_s = ST_WAIT_DONE;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_CORE_HOLD: begin
            if (!pll_locked_s || !gt_reset_done_s) begin
               state_nxt_s = ST_WAIT_LOCK;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == HOLD_LAST) begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_RUN: begin
            if (!pll_locked_s || !gt_reset_done_s) begin
               state_nxt_s = ST_WAIT_LOCK;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               cnt_nxt_s = CNT_ZERO;
            end
         end
         ST_FAIL: begin
            cnt_nxt_s = CNT_ZERO;
         end
         default: begin
            state_nxt_s = ST_WAIT_LOCK;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // output decode of the current state
   always_comb begin
      gt_reset_nxt_s   = 1'b1;
      core_reset_nxt_s = 1'b1;
      seq_done_nxt_s   = 1'b0;
      seq_error_nxt_s  = 1'b0;
      case (state_r)
         ST_WAIT_LOCK: gt_reset_nxt_s = 1'b1;
         ST_WAIT_DONE: gt_reset_nxt_s = 1'b0;
         ST_RETRY:     gt_reset_nxt_s = 1'b1;
         ST_CORE_HOLD: gt_reset_nxt_s = 1'b0;
         ST_RUN: begin
            gt_reset_nxt_s   = 1'b0;
            core_reset_nxt_s = 1'b0;
            seq_done_nxt_s   = 1'b1;
         end
         ST_FAIL:      seq_error_nxt_s = 1'b1;
         default:      gt_reset_nxt_s = 1'b1;
      endcase
   end

   // registered outputs, one cycle behind the state they decode
   always_ff @(posedge coreclk or posedge rst) begin
      if (rst) begin
         gt_reset    <= 1'b1;
         core_reset  <= 1'b1;
         seq_done    <= 1'b0;
         seq_error   <= 1'b0;
         retry_count <= 4'd0;
      end else begin
         gt_reset    <= gt_reset_nxt_s;
         core_reset  <= core_reset_nxt_s;
         seq_done    <= seq_done_nxt_s;
         seq_error   <= seq_error_nxt_s;
         retry_count <= retry_r;
      end
   end

endmodule

// File: tb/tb_jesd_reset_seq.sv
// Bench for jesd_reset_seq: directed scenarios plus random lock/done activity,
// all cycles compared against a phase/duration model of the sequencer.
module tb_jesd_reset_seq;

   localparam int STABLE = 8;
   localparam int TMO    = 32;
   localparam int PULSE  = 4;
   localparam int HOLD   = 4;
   localparam int RMAX   = 3;

   logic       coreclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       gt_reset_done = 1'b0;
   logic       gt_reset, core_reset, seq_done, seq_error;
   logic [3:0] retry_count;

   int n_vec = 0;
   int n_err = 0;

   jesd_reset_seq #(
      .STABLE_CYCLES(STABLE), .DONE_TIMEOUT(TMO), .GT_RST_PULSE(PULSE),
      .CORE_HOLD(HOLD), .RETRY_MAX(RMAX)
   ) dut (
      .coreclk(coreclk), .rst(rst), .pll_locked(pll_locked), .gt_reset_done(gt_reset_done),
      .gt_reset(gt_reset), .core_reset(core_reset), .seq_done(seq_done),
      .seq_error(seq_error), .retry_count(retry_count)
   );

   always #5 coreclk = ~coreclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phases of the sequence plus how long each has lasted.
   typedef enum int {P_LOCKING, P_GT_UP, P_PULSE, P_HOLD, P_READY, P_DEAD} phase_t;
   phase_t phase;
   int     run_len, age, tries;
   logic   lk1, lk2, dn1, dn2;
   logic   e_gt, e_core, e_done, e_err;
   logic [3:0] e_retry;

   task automatic model_reset();
      phase = P_LOCKING; run_len = 0; age = 0; tries = 0;
      lk1 = 1'b0; lk2 = 1'b0; dn1 = 1'b0; dn2 = 1'b0;
      e_gt = 1'b1; e_core = 1'b1; e_done = 1'b0; e_err = 1'b0; e_retry = 4'd0;
   endtask

   task automatic model_step();
      logic lock, done;
      // outputs show the phase that occupied the cycle now ending
      e_gt    = !(phase == P_GT_UP || phase == P_HOLD || phase == P_READY);
      e_core  = (phase != P_READY);
      e_done  = (phase == P_READY);
      e_err   = (phase == P_DEAD);
      e_retry = 4'(tries);
      lock = lk2;
      done = dn2;
      case (phase)
         P_LOCKING: begin
            run_len = lock ? run_len + 1 : 0;
            if (run_len == STABLE) begin phase = P_GT_UP; age = 0; run_len = 0; end
         end
         P_GT_UP: begin
            age++;
            if (done) begin phase = P_HOLD; age = 0; end
            else if (!lock) begin phase = P_LOCKING; run_len = 0; end
            else if (age == TMO) begin
               age = 0;
               if (tries == RMAX) phase = P_DEAD;
               else begin tries = (tries < 15) ? tries + 1 : 15; phase = P_PULSE; end
            end
         end
         P_PULSE: begin
            age++;
            if (age == PULSE) begin phase = P_GT_UP; age = 0; end
         end
         P_HOLD: begin
            age++;
            if (!lock || !done) begin phase = P_LOCKING; run_len = 0; end
            else if (age == HOLD) phase = P_READY;
         end
         P_READY: if (!lock || !done) begin phase = P_LOCKING; run_len = 0; end
         default: ;
      endcase
      lk2 = lk1; lk1 = pll_locked;
      dn2 = dn1; dn1 = gt_reset_done;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge coreclk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   // every-cycle comparison against the model, away from the active edge
   initial begin
      forever begin
         @(negedge coreclk);
         check("gt_reset", 32'(gt_reset), 32'(e_gt));
         check("core_reset", 32'(core_reset), 32'(e_core));
         check("seq_done", 32'(seq_done), 32'(e_done));
         check("seq_error", 32'(seq_error), 32'(e_err));
         check("retry_count", 32'(retry_count), 32'(e_retry));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      pll_locked = 1'b0;
      gt_reset_done = 1'b0;
      @(negedge coreclk); #2 rst = 1'b1;
      @(negedge coreclk); #2 rst = 1'b0;
      @(negedge coreclk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_gt"}, 32'(gt_reset), 32'd1);
      check({tag, "_core"}, 32'(core_reset), 32'd1);
      check({tag, "_done"}, 32'(seq_done), 32'd0);
      check({tag, "_err"}, 32'(seq_error), 32'd0);
      check({tag, "_retry"}, 32'(retry_count), 32'd0);
   endtask

   int lat, pulses, width, seg_len;
   logic prev_gt, in_pulse;
   int rc[3];

   initial begin
      // reset state
      repeat (3) @(negedge coreclk);
      check_reset_values("por");
      #2 rst = 1'b0;
      repeat (3) @(negedge coreclk);

      // nominal: 2 sync + 8 stable + 1 register = 11 edges to gt release
      pll_locked = 1'b1;
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge coreclk);
         if (gt_reset == 1'b0) begin lat = i; break; end
      end
      check("lock_latency", 32'(lat), 32'd11);
      repeat (4) @(negedge coreclk);
      gt_reset_done = 1'b1;
      for (int i = 0; i < 60 && seq_done !== 1'b1; i++) @(negedge coreclk);
      check("nominal_done", 32'(seq_done), 32'd1);
      check("nominal_core", 32'(core_reset), 32'd0);

      // loss of lock in RUN
      pll_locked = 1'b0;
      repeat (6) @(negedge coreclk);
      check("loss_gt", 32'(gt_reset), 32'd1);
      check("loss_done", 32'(seq_done), 32'd0);
      pll_locked = 1'b1;
      for (int i = 0; i < 80 && seq_done !== 1'b1; i++) @(negedge coreclk);
      check("relock_done", 32'(seq_done), 32'd1);

      // glitchy lock: high 5, low 1, then high -> release at edge 17
      do_reset();
      pll_locked = 1'b1;
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge coreclk);
         if (i == 5) pll_locked = 1'b0;
         if (i == 6) pll_locked = 1'b1;
         if (gt_reset == 1'b0) begin lat = i; break; end
      end
      check("glitch_latency", 32'(lat), 32'd17);

      // async reset in the middle of WAIT_DONE
      do_reset();
      pll_locked = 1'b1;
      repeat (20) @(negedge coreclk);
      check("wd_gt_low", 32'(gt_reset), 32'd0);
      #2 rst = 1'b1;
      #1 check_reset_values("rst_wd");
      @(negedge coreclk); #2 rst = 1'b0;

      // timeout and retries until FAIL
      do_reset();
      pll_locked = 1'b1;
      pulses = 0; width = 0; in_pulse = 1'b0; prev_gt = gt_reset;
      for (int k = 0; k < 3; k++) rc[k] = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge coreclk);
         if (seq_error) break;
         if (gt_reset && !prev_gt) begin
            pulses++; in_pulse = 1'b1; width = 1;
            if (pulses <= 3) rc[pulses-1] = 32'(retry_count);
         end else if (gt_reset && in_pulse) begin
            width++;
         end else if (!gt_reset && in_pulse) begin
            in_pulse = 1'b0;
            check($sformatf("pulse%0d_width", pulses), 32'(width), 32'd4);
         end
         prev_gt = gt_reset;
      end
      check("retry_pulses", 32'(pulses), 32'd3);
      check("retry_rc1", 32'(rc[0]), 32'd1);
      check("retry_rc2", 32'(rc[1]), 32'd2);
      check("retry_rc3", 32'(rc[2]), 32'd3);
      repeat (40) @(negedge coreclk);
      check("fail_err", 32'(seq_error), 32'd1);
      check("fail_gt", 32'(gt_reset), 32'd1);
      check("fail_core", 32'(core_reset), 32'd1);
      check("fail_retry", 32'(retry_count), 32'd3);

      // async reset while in FAIL
      #2 rst = 1'b1;
      #1 check_reset_values("rst_fail");
      @(negedge coreclk); #2 rst = 1'b0;

      // recovery on the second attempt
      do_reset();
      pll_locked = 1'b1;
      for (int i = 0; i < 200 && retry_count != 4'd1; i++) @(negedge coreclk);
      gt_reset_done = 1'b1;
      for (int i = 0; i < 100 && seq_done !== 1'b1; i++) @(negedge coreclk);
      check("recov_done", 32'(seq_done), 32'd1);
      check("recov_err", 32'(seq_error), 32'd0);
      check("recov_retry", 32'(retry_count), 32'd1);
      pll_locked = 1'b0;
      repeat (5) @(negedge coreclk);
      pll_locked = 1'b1;
      for (int i = 0; i < 100 && seq_done !== 1'b1; i++) @(negedge coreclk);
      check("relock2_done", 32'(seq_done), 32'd1);
      check("relock2_retry", 32'(retry_count), 32'd1);

      // random lock/done activity with occasional asynchronous resets
      do_reset();
      for (int s = 0; s < 60; s++) begin
         seg_len = $urandom_range(1, 70);
         pll_locked = ($urandom_range(0, 7) != 0);
         gt_reset_done = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0) begin
            #2 rst = 1'b1;
            @(negedge coreclk); #2 rst = 1'b0;
         end
         repeat (seg_len) @(negedge coreclk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
